// File: rtl/bus_cycle_pkg.sv
// Shared types and constants for the 8205 chip-select bus cycle sequencer.
package bus_cycle_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_T1   = 3'd1,
    S_T2   = 3'd2,
    S_TW   = 3'd3,
    S_T3   = 3'd4,
    S_T4   = 3'd5,
    S_HOLD = 3'd6
  } bus_state_e;

  localparam logic [2:0] E_ENABLE  = 3'b100;
  localparam logic [2:0] E_DISABLE = 3'b011;

endpackage

// File: rtl/bus_wait_counter.sv
// Wait-state counter: loads the bank wait count, decrements in TW,
// flags zero (skip TW) and last (final TW cycle).
module bus_wait_counter #(
  parameter int WAIT_W = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_load,
  input  logic [WAIT_W-1:0] i_val,
  input  logic              i_dec,
  output logic              o_zero,
  output logic              o_last
);

  logic [WAIT_W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_val;
    end else if (i_dec && r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);
  assign o_last = (r_cnt == WAIT_W'(1));

endmodule

// File: rtl/bus_cycle_sequencer.sv
// T1/T2/TW/T3/T4 bus cycle driver for an 8205-style 3:8 decoder.
// Optional bus hold handshake (HOLD/HLDA) when BUS_SEQ_HOLD_EN is defined.
module bus_cycle_sequencer
  import bus_cycle_pkg::*;
#(
  parameter int ADDR_W   = 16,
  parameter int BANK_LSB = 13,
  parameter int WAIT_W   = 2
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                REQ,
  input  logic                RD_WR,
  input  logic [ADDR_W-1:0]   ADDR,
  input  logic [8*WAIT_W-1:0] WAIT_CFG,
`ifdef BUS_SEQ_HOLD_EN
  input  logic                HOLD,
  output logic                HLDA,
`endif
  output logic                ALE,
  output logic [2:0]          A_SEL,
  output logic [2:0]          E_OUT,
  output logic                RD_N,
  output logic                WR_N,
  output logic                ACK,
  output logic                BUSY
);

  bus_state_e        r_state;
  logic              r_rd;
  logic [2:0]        w_bank;
  logic [WAIT_W-1:0] w_wait;
  logic              w_hold;
  logic              w_load;
  logic              w_zero;
  logic              w_last;
  logic              w_unused;

  assign w_bank = ADDR[BANK_LSB+2:BANK_LSB];
  assign w_wait = WAIT_CFG[int'(w_bank)*WAIT_W +: WAIT_W];
  assign w_unused = ^ADDR;

`ifdef BUS_SEQ_HOLD_EN
  assign w_hold = HOLD;
`else
  assign w_hold = 1'b0;
`endif

  // HOLD takes precedence over a pending request in IDLE
  assign w_load = (r_state == S_IDLE) && REQ && !w_hold;

  bus_wait_counter #(.WAIT_W(WAIT_W)) u_wait (
    .i_clk  (CLK),
    .i_rst  (RST),
    .i_load (w_load),
    .i_val  (w_wait),
    .i_dec  (r_state == S_TW),
    .o_zero (w_zero),
    .o_last (w_last)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_rd    <= 1'b0;
      ALE     <= 1'b0;
      A_SEL   <= 3'd0;
      E_OUT   <= E_DISABLE;
      RD_N    <= 1'b1;
      WR_N    <= 1'b1;
      ACK     <= 1'b0;
      BUSY    <= 1'b0;
`ifdef BUS_SEQ_HOLD_EN
      HLDA    <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_hold) begin
            r_state <= S_HOLD;
            BUSY    <= 1'b1;
`ifdef BUS_SEQ_HOLD_EN
            HLDA    <= 1'b1;
`endif
          end else if (REQ) begin
            r_state <= S_T1;
            r_rd    <= RD_WR;
            ALE     <= 1'b1;
            A_SEL   <= w_bank;
            E_OUT   <= E_DISABLE;
            BUSY    <= 1'b1;
          end
        end
        S_T1: begin
          r_state <= S_T2;
          ALE     <= 1'b0;
          E_OUT   <= E_ENABLE;
          RD_N    <= ~r_rd;
          WR_N    <= r_rd;
        end
        S_T2: begin
          if (w_zero) begin
            r_state <= S_T3;
            ACK     <= 1'b1;
          end else begin
            r_state <= S_TW;
          end
        end
        S_TW: begin
          if (w_last) begin
            r_state <= S_T3;
            ACK     <= 1'b1;
          end
        end
        S_T3: begin
          r_state <= S_T4;
          ACK     <= 1'b0;
          E_OUT   <= E_DISABLE;
          RD_N    <= 1'b1;
          WR_N    <= 1'b1;
        end
        S_T4: begin
          r_state <= S_IDLE;
          BUSY    <= 1'b0;
        end
        S_HOLD: begin
          if (!w_hold) begin
            r_state <= S_IDLE;
            BUSY    <= 1'b0;
`ifdef BUS_SEQ_HOLD_EN
            HLDA    <= 1'b0;
`endif
          end
        end
        default: begin
          r_state <= S_IDLE;
          BUSY    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_cycle_sequencer.sv
// Directed bench for bus_cycle_sequencer; define BUS_SEQ_HOLD_EN to
// also exercise the HOLD/HLDA path.
module tb_bus_cycle_sequencer;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        REQ = 1'b0;
  logic        RD_WR = 1'b0;
  logic [15:0] ADDR = '0;
  logic [15:0] WAIT_CFG = '0;
  logic        ALE;
  logic [2:0]  A_SEL;
  logic [2:0]  E_OUT;
  logic        RD_N;
  logic        WR_N;
  logic        ACK;
  logic        BUSY;
`ifdef BUS_SEQ_HOLD_EN
  logic        HOLD = 1'b0;
  logic        HLDA;
`endif

  int n_chk = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  bus_cycle_sequencer #(
    .ADDR_W(16), .BANK_LSB(13), .WAIT_W(2)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .REQ      (REQ),
    .RD_WR    (RD_WR),
    .ADDR     (ADDR),
    .WAIT_CFG (WAIT_CFG),
`ifdef BUS_SEQ_HOLD_EN
    .HOLD     (HOLD),
    .HLDA     (HLDA),
`endif
    .ALE      (ALE),
    .A_SEL    (A_SEL),
    .E_OUT    (E_OUT),
    .RD_N     (RD_N),
    .WR_N     (WR_N),
    .ACK      (ACK),
    .BUSY     (BUSY)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    check({tag, "_ale"}, 32'(ALE), 0);
    check({tag, "_e"}, 32'(E_OUT), 32'h3);
    check({tag, "_rdn"}, 32'(RD_N), 1);
    check({tag, "_wrn"}, 32'(WR_N), 1);
    check({tag, "_ack"}, 32'(ACK), 0);
    check({tag, "_busy"}, 32'(BUSY), 0);
  endtask

  int wr_lo, rd_lo, e_on, ack_at;

  initial begin
    // bank1 waits=1, bank2 waits=3, others 0
    WAIT_CFG = 16'h0034;
    tick();
    tick();
    chk_idle("rst");
    check("rst_asel", 32'(A_SEL), 0);
`ifdef BUS_SEQ_HOLD_EN
    check("rst_hlda", 32'(HLDA), 0);
`endif
    RST = 1'b0;
    tick();
    check("idle_busy", 32'(BUSY), 0);

    // read, bank 5, no waits
    REQ = 1'b1; ADDR = 16'hA000; RD_WR = 1'b1;
    tick();
    check("rd_t1_ale", 32'(ALE), 1);
    check("rd_t1_asel", 32'(A_SEL), 5);
    check("rd_t1_e", 32'(E_OUT), 32'h3);
    check("rd_t1_busy", 32'(BUSY), 1);
    check("rd_t1_rdn", 32'(RD_N), 1);
    RD_WR = 1'b0; ADDR = 16'h4000;
    tick();
    check("rd_t2_ale", 32'(ALE), 0);
    check("rd_t2_e", 32'(E_OUT), 32'h4);
    check("rd_t2_rdn", 32'(RD_N), 0);
    check("rd_t2_wrn", 32'(WR_N), 1);
    check("rd_t2_ack", 32'(ACK), 0);
    tick();
    check("rd_t3_ack", 32'(ACK), 1);
    check("rd_t3_rdn", 32'(RD_N), 0);
    REQ = 1'b0;
    tick();
    check("rd_t4_ack", 32'(ACK), 0);
    check("rd_t4_e", 32'(E_OUT), 32'h3);
    check("rd_t4_rdn", 32'(RD_N), 1);
    check("rd_t4_busy", 32'(BUSY), 1);
    check("rd_t4_asel", 32'(A_SEL), 5);
    tick();
    chk_idle("rd_end");

    // write, bank 2, three waits; config change mid-cycle is ignored
    REQ = 1'b1; ADDR = 16'h4000; RD_WR = 1'b0;
    tick();
    check("wr_t1_asel", 32'(A_SEL), 2);
    check("wr_t1_ale", 32'(ALE), 1);
    WAIT_CFG = 16'h0000;
    wr_lo = 0; rd_lo = 0; e_on = 0; ack_at = 0;
    for (int i = 1; i <= 9; i++) begin
      tick();
      if (!WR_N) wr_lo++;
      if (!RD_N) rd_lo++;
      if (E_OUT == 3'b100) e_on++;
      if (ACK && ack_at == 0) begin
        ack_at = i;
        REQ = 1'b0;
      end
    end
    check("wr_wrn_cycles", 32'(wr_lo), 5);
    check("wr_rdn_cycles", 32'(rd_lo), 0);
    check("wr_e_cycles", 32'(e_on), 5);
    check("wr_ack_at", 32'(ack_at), 5);
    chk_idle("wr_end");
    WAIT_CFG = 16'h0034;

    // back-to-back: REQ held across ACK, new bank 1 (one wait)
    REQ = 1'b1; ADDR = 16'hA000; RD_WR = 1'b1;
    tick();
    tick();
    tick();
    check("b2b_ack1", 32'(ACK), 1);
    ADDR = 16'h2000;
    tick();
    check("b2b_t4_busy", 32'(BUSY), 1);
    tick();
    check("b2b_idle_busy", 32'(BUSY), 0);
    check("b2b_idle_e", 32'(E_OUT), 32'h3);
    tick();
    check("b2b_t1_ale", 32'(ALE), 1);
    check("b2b_t1_asel", 32'(A_SEL), 1);
    check("b2b_t1_e", 32'(E_OUT), 32'h3);
    tick();
    check("b2b_t2_ack", 32'(ACK), 0);
    tick();
    check("b2b_tw_ack", 32'(ACK), 0);
    check("b2b_tw_rdn", 32'(RD_N), 0);
    tick();
    check("b2b_ack2", 32'(ACK), 1);
    REQ = 1'b0;
    tick();
    tick();
    chk_idle("b2b_end");

    // reset while in TW aborts the cycle
    REQ = 1'b1; ADDR = 16'h4000; RD_WR = 1'b0;
    tick();
    tick();
    tick();
    check("mrst_tw_wrn", 32'(WR_N), 0);
    check("mrst_tw_busy", 32'(BUSY), 1);
    RST = 1'b1; REQ = 1'b0;
    tick();
    chk_idle("mrst");
    check("mrst_asel", 32'(A_SEL), 0);
    RST = 1'b0;
    tick();
    chk_idle("mrst_post");

    // a zero-wait cycle right after the abort
    REQ = 1'b1; ADDR = 16'hA000; RD_WR = 1'b1;
    tick();
    tick();
    tick();
    check("post_ack", 32'(ACK), 1);
    REQ = 1'b0;
    tick();
    tick();
    chk_idle("post_end");

`ifdef BUS_SEQ_HOLD_EN
    HOLD = 1'b1; REQ = 1'b1; ADDR = 16'hA000; RD_WR = 1'b1;
    tick();
    check("hold_hlda", 32'(HLDA), 1);
    check("hold_ale", 32'(ALE), 0);
    check("hold_e", 32'(E_OUT), 32'h3);
    tick();
    check("hold_hlda2", 32'(HLDA), 1);
    check("hold_ale2", 32'(ALE), 0);
    HOLD = 1'b0;
    tick();
    check("hold_rel_hlda", 32'(HLDA), 0);
    check("hold_rel_ale", 32'(ALE), 0);
    tick();
    check("hold_t1_ale", 32'(ALE), 1);
    check("hold_t1_asel", 32'(A_SEL), 5);
    tick();
    tick();
    check("hold_ack", 32'(ACK), 1);
    REQ = 1'b0;
    tick();
    tick();
    chk_idle("hold_end");
`endif

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
